// File: rtl/audio_codec_config_queue_if.sv
// Command/busy bundle between a config sequencer and the shared i2c write controller.
interface audio_codec_config_queue_if;
  logic [6:0] address;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic       i2c_start;
  logic       i2c_busy;

  modport master (output address, output data_0, output data_1, output i2c_start, input i2c_busy);
  modport slave  (input address, input data_0, input data_1, input i2c_start, output i2c_busy);
endinterface

// File: rtl/audio_codec_config_queue.sv
// Walks the fixed 9-entry codec register table into the i2c write controller,
// one strobed command per entry, with a busy-rise timeout and a fixed inter-command gap.
module audio_codec_config_queue #(
  parameter logic [6:0] DEV_ADDR     = 7'h1A,
  parameter int         NUM_CMDS     = 9,
  parameter int         BUSY_TIMEOUT = 16,
  parameter int         GAP_CYCLES   = 25
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  audio_codec_config_queue_if.master  i2c,
  output logic [3:0]                  index,
  output logic                        done,
  output logic                        error
);

  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_CMDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DRAIN, S_LOAD, S_STROBE, S_WAIT_HI, S_WAIT_LO, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       d0_q, d1_q;

  // Entry layout {reg[6:0], data[8:0]}: the upper byte is exactly data_0.
  function automatic logic [15:0] entry(input logic [3:0] i);
    case (i)
      4'd0:    entry = {7'd15, 9'h000};
      4'd1:    entry = {7'd6,  9'h012};
      4'd2:    entry = {7'd0,  9'h017};
      4'd3:    entry = {7'd1,  9'h017};
      4'd4:    entry = {7'd4,  9'h012};
      4'd5:    entry = {7'd5,  9'h000};
      4'd6:    entry = {7'd7,  9'h042};
      4'd7:    entry = {7'd8,  9'h000};
      4'd8:    entry = {7'd9,  9'h001};
      default: entry = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    i2c.i2c_start = 1'b0;
    i2c.address   = (state == S_IDLE) ? 7'd0 : DEV_ADDR;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_n = S_DRAIN;
      S_DRAIN:   if (!i2c.i2c_busy) state_n = S_LOAD;
      S_LOAD:    state_n = S_STROBE;
      S_STROBE: begin
        i2c.i2c_start = 1'b1;
        state_n       = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (i2c.i2c_busy)        state_n = S_WAIT_LO;
        else if (cnt == TO_LAST) state_n = S_ERROR;
      end
      S_WAIT_LO: if (!i2c.i2c_busy) state_n = S_GAP;
      S_GAP:     if (cnt == GAP_LAST) state_n = (index == IDX_LAST) ? S_DONE : S_LOAD;
      default:   state_n = S_IDLE;
    endcase
  end

  // Data bytes are registered on the edge into LOAD so they lead the strobe by a cycle
  // and stay put until the next LOAD, which cannot happen while busy is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      index <= 4'd0;
      done  <= 1'b0;
      error <= 1'b0;
      d0_q  <= 8'd0;
      d1_q  <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            index <= 4'd0;
            done  <= 1'b0;
            error <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!i2c.i2c_busy) begin
            d0_q <= entry(index)[15:8];
            d1_q <= entry(index)[7:0];
          end
        end
        S_STROBE: cnt <= '0;
        S_WAIT_HI: begin
          if (!i2c.i2c_busy) begin
            cnt <= cnt + 1'b1;
            if (cnt == TO_LAST) error <= 1'b1;
          end
        end
        S_WAIT_LO: cnt <= '0;
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (index == IDX_LAST) begin
              done <= 1'b1;
            end else begin
              index <= index + 4'd1;
              d0_q  <= entry(index + 4'd1)[15:8];
              d1_q  <= entry(index + 4'd1)[7:0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c.data_0 = d0_q;
  assign i2c.data_1 = d1_q;

endmodule

// File: tb/tb_audio_codec_config_queue.sv
// Bench for audio_codec_config_queue: busy-responding controller model, strobe scoreboard
// and directed scenarios with randomised busy timing and start injection.
module tb_audio_codec_config_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  logic [3:0] index;
  logic done, error;

  audio_codec_config_queue_if bus ();
  assign bus.i2c_busy = model_busy | force_busy;

  audio_codec_config_queue dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .i2c   (bus),
    .index (index),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference table: register number and 9-bit value of each command.
  int ref_reg [9] = '{15, 6, 0, 1, 4, 5, 7, 8, 9};
  int ref_dat [9] = '{'h000, 'h012, 'h017, 'h017, 'h012, 'h000, 'h042, 'h000, 'h001};

  int checks = 0;
  int errors = 0;

  // Strobe scoreboard and busy-fall log.
  int st_cyc [$];
  int st_d0 [$];
  int st_d1 [$];
  int st_addr [$];
  int fall_cyc [$];
  int stab_err = 0;

  initial begin
    logic prev_b, in_x;
    int xd0, xd1, xa;
    prev_b = 1'b0;
    in_x   = 1'b0;
    xd0 = 0; xd1 = 0; xa = 0;
    forever begin
      @(negedge clk);
      if (bus.i2c_start) begin
        st_cyc.push_back(cyc);
        st_d0.push_back(int'(bus.data_0));
        st_d1.push_back(int'(bus.data_1));
        st_addr.push_back(int'(bus.address));
        in_x = 1'b1;
        xd0 = int'(bus.data_0); xd1 = int'(bus.data_1); xa = int'(bus.address);
      end else if (in_x && bus.i2c_busy && !rst &&
                   (int'(bus.data_0) != xd0 || int'(bus.data_1) != xd1 || int'(bus.address) != xa)) begin
        stab_err++;
      end
      if (prev_b && !bus.i2c_busy) begin
        fall_cyc.push_back(cyc);
        in_x = 1'b0;
      end
      if (rst) in_x = 1'b0;
      prev_b = bus.i2c_busy;
    end
  end

  // Controller model: busy rises d cycles after a strobe and holds h cycles.
  int  kill_at = 1000;
  bit  rnd = 1'b0;
  initial begin
    int d, h, msc;
    msc = 0;
    forever begin
      @(negedge clk);
      if (bus.i2c_start) begin
        msc++;
        if (msc - 1 < kill_at) begin
          d = rnd ? int'($urandom_range(1, 4)) : 2;
          h = rnd ? int'($urandom_range(1, 15)) : 10;
          repeat (d) @(posedge clk);
          #1 model_busy = 1'b1;
          repeat (h) @(posedge clk);
          #1 model_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      tick(1);
      k++;
    end
    chk(tag, done, 1);
  endtask

  // Checks a complete 9-command run starting at scoreboard position base.
  task automatic check_seq(input string tag, input int base);
    int n, last_fall;
    n = st_cyc.size() - base;
    chk({tag, "_count"}, n, 9);
    if (n > 9) n = 9;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), st_addr[base+k], 'h1A);
      chk($sformatf("%s_d0_%0d", tag, k), st_d0[base+k], ref_reg[k] * 2 + ref_dat[k] / 256);
      chk($sformatf("%s_d1_%0d", tag, k), st_d1[base+k], ref_dat[k] % 256);
    end
    for (int k = 1; k < n; k++) begin
      last_fall = -1;
      foreach (fall_cyc[j]) if (fall_cyc[j] < st_cyc[base+k]) last_fall = fall_cyc[j];
      chk($sformatf("%s_gap%0d", tag, k), st_cyc[base+k] - last_fall, 27);
    end
  endtask

  initial begin
    int base, c0, fc, ec, k;

    // Reset state, and start colliding with reset.
    rst = 1'b1;
    tick(3);
    chk("rst_addr", bus.address, 0);
    chk("rst_d0", bus.data_0, 0);
    chk("rst_d1", bus.data_1, 0);
    chk("rst_strobe", bus.i2c_start, 0);
    chk("rst_index", index, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("rst_wins_addr", bus.address, 0);
    rst = 1'b0;
    tick(6);
    chk("rst_wins_nostrobe", st_cyc.size(), 0);
    chk("rst_wins_idle", bus.address, 0);

    // Nominal run with fixed busy timing.
    base = st_cyc.size();
    c0 = cyc;
    pulse_start();
    wait_done("a_done", 1500);
    if (st_cyc.size() > base) chk("a_latency", st_cyc[base] - c0, 3);
    check_seq("a", base);
    chk("a_index", index, 8);
    chk("a_error", error, 0);
    tick(60);
    chk("a_nomore", st_cyc.size() - base, 9);

    // Randomised busy delay and length.
    rnd = 1'b1;
    base = st_cyc.size();
    pulse_start();
    chk("r_done_clr", done, 0);
    wait_done("r_done", 2000);
    check_seq("r", base);
    rnd = 1'b0;

    // Controller already busy when start arrives.
    force_busy = 1'b1;
    base = st_cyc.size();
    pulse_start();
    tick(40);
    chk("fb_nostrobe", st_cyc.size() - base, 0);
    force_busy = 1'b0;
    fc = cyc;
    wait_done("fb_done", 1500);
    if (st_cyc.size() > base) chk("fb_first", st_cyc[base] - fc, 2);
    check_seq("fb", base);

    // Busy never rises after strobe 3.
    base = st_cyc.size();
    kill_at = base + 3;
    pulse_start();
    k = 0;
    while (!error && k < 1500) begin
      tick(1);
      k++;
    end
    ec = cyc;
    chk("to_error", error, 1);
    if (st_cyc.size() > base + 3) chk("to_delay", ec - (st_cyc[base+3] + 1), 16);
    chk("to_index", index, 3);
    chk("to_done", done, 0);
    tick(60);
    chk("to_count", st_cyc.size() - base, 4);
    chk("to_hold", error, 1);
    kill_at = 1000;

    // Restart from ERROR with stray start pulses during the run.
    base = st_cyc.size();
    pulse_start();
    chk("xs_err_clr", error, 0);
    for (int j = 0; j < 2000 && !done; j++) begin
      if ($urandom_range(0, 9) == 0) start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    chk("xs_done", done, 1);
    check_seq("xs", base);

    // Start after DONE restarts from entry 0.
    base = st_cyc.size();
    pulse_start();
    chk("rs_done_clr", done, 0);
    chk("rs_index", index, 0);
    wait_done("rs_done", 1500);
    check_seq("rs", base);

    // Reset while waiting for busy to fall on entry 4.
    base = st_cyc.size();
    pulse_start();
    k = 0;
    while (!(st_cyc.size() == base + 5 && bus.i2c_busy) && k < 2000) begin
      tick(1);
      k++;
    end
    chk("mr_reached", st_cyc.size() - base, 5);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("mr_addr", bus.address, 0);
    chk("mr_d0", bus.data_0, 0);
    chk("mr_d1", bus.data_1, 0);
    chk("mr_strobe", bus.i2c_start, 0);
    chk("mr_index", index, 0);
    chk("mr_done", done, 0);
    chk("mr_error", error, 0);
    rst = 1'b0;
    k = 0;
    while (bus.i2c_busy && k < 100) begin
      tick(1);
      k++;
    end
    tick(30);
    chk("mr_quiet", st_cyc.size() - base, 5);
    base = st_cyc.size();
    c0 = cyc;
    pulse_start();
    wait_done("mr_done2", 1500);
    if (st_cyc.size() > base) chk("mr_latency", st_cyc[base] - c0, 3);
    check_seq("mr", base);

    chk("stable_while_busy", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
